spi_ram_master: RTL
===================

Name: spi_ram_master

Overview:
- SPI master that generates the serial packets consumed by spi_top, the SPI-slave register RAM, directly upstream of it.
- Accepts parallel read/write requests on a valid/ready interface.
- Serialises each request into the SPI-RAM packet format LSB-first; for reads, captures the 8-bit MISO response and returns it on a response strobe.
- Replaces bench-driven SPI stimulus when the RAM is driven from on-chip logic.

Parameters:
- CLK_DIV, 2, clk cycles per spi_clk half-period (>=1; spi_clk = clk/(2*CLK_DIV)).
- CS_GAP, 3, minimum full spi_clk periods with spi_cs high between transactions.
- DUMMY_BITS, 7, idle spi_clk cycles between read command byte and first read-data bit.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle; request accepted when req_valid && req_ready.
- req_write  in  1  1 = write packet, 0 = read packet.
- req_addr  in  4  RAM address.
- req_wdata  in  8  write data (ignored for reads).
- rsp_valid  out  1  one-cycle pulse: rsp_rdata valid (reads only).
- rsp_rdata  out  8  last read data; held until the next read completes.
- busy  out  1  high from acceptance through end of CS gap.
- spi_clk  out  1  SPI clock, idle low (mode 0).
- spi_cs  out  1  chip select, active low.
- spi_mosi  out  1  master-out data.
- spi_miso  in  1  slave-out data.

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- Reset values: req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, spi_clk=0, spi_cs=1, spi_mosi=0. FSM to IDLE, counters cleared.
- Reset mid-transaction: the next edge forces the reset values. Any partial read is discarded with no rsp_valid; spi_cs rises immediately.
- Packet formats (bit 0 first on wire):
  - Write, 16 bits: {data[7:0], addr[3:0], CMD_WR=4'h1}.
  - Read, 8 bits: {addr[3:0], CMD_RD=4'h2}, then DUMMY_BITS clocks with mosi=0, then 8 clocks sampling miso into rdata[0..7] with mosi=0.
  - Rising edges per transaction: write 16, read 8+DUMMY_BITS+8=23.
- Edge rules: mosi changes only while spi_clk is low, at the start of each low half-period. The slave samples mosi on spi_clk rising edge. The master samples miso in the clk cycle in which spi_clk goes high, for rising edges 8+DUMMY_BITS .. 15+DUMMY_BITS (0-based).
- FSM states:
  - IDLE: req_ready=1. On accept, latch the request into the shift register and bit count, then go to SETUP.
  - SETUP, CLK_DIV cycles: spi_cs=0, spi_clk=0, mosi=bit0.
  - SHIFT_HI, CLK_DIV cycles: spi_clk=1. Sample miso when in a read-data window.
  - SHIFT_LO, CLK_DIV cycles: spi_clk=0, mosi advances to the next bit. After the last bit go to HOLD, else go to SHIFT_HI.
  - HOLD, CLK_DIV cycles: spi_clk=0, spi_cs=0.
  - GAP, CS_GAP*2*CLK_DIV cycles: spi_cs=1. On entry, reads pulse rsp_valid for one cycle and update rsp_rdata. Then go to IDLE.
- Timing at defaults (CLK_DIV=2, CS_GAP=3):
  - spi_cs low: write 68 clk, read 96 clk.
  - spi_cs high between back-to-back requests: >=12 clk.
  - Next acceptance: 1 cycle after GAP ends.
- req_ready=0 outside IDLE; requests are never dropped, only stalled.
- Division counter width: clog2(CLK_DIV*2*CS_GAP+1). Bit counter: 5 bits.

Optional Feature:
- Macro SPI_MASTER_STATS_EN.
- Defined: adds outputs wr_count[15:0] and rd_count[15:0]. Each increments on entry to GAP for its transaction type, wraps 0xFFFF->0, and clears on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package spi_ram_pkg holds:
  - CMD_WR=4'h1, CMD_RD=4'h2, ADDR_W=4, DATA_W=8, CMD_W=4.
  - WR_BITS=16, RD_CMD_BITS=8.
  - FSM state enum {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP}.
- spi_top imports CMD_* from the same package.
- One sub-module, spi_clk_div: half-period tick generator with enable and synchronous clear.

Test Plan:
- Write addr 0 data 0xAA -> mosi sequence 1,0,0,0, 0,0,0,0, 0,1,0,1, 0,1,0,1 sampled at 16 rising edges; spi_cs low 68 clk; no rsp_valid.
- Read addr 3, MISO model driving 0xDD LSB-first from rising edge 15 -> mosi 0,1,0,0,1,1,0,0 then zeros; 23 rising edges; rsp_valid single pulse; rsp_rdata=0xDD.
- req_valid held with two writes back-to-back -> second accepted only after GAP; spi_cs high >=12 clk; req_ready=0 throughout the first transaction.
- Reset asserted at rising edge 9 of a read -> next clk spi_cs=1, spi_clk=0, req_ready=1, no rsp_valid; a subsequent write completes correctly.
- Integration with spi_top: write 16 addresses (0xAA, 0xBB, 0xCC, 0xDD, 0xFF, 0x09, 0x08, 0x0A, 0x0B, 0xBC, 0xDE, 0xEE, 0x0C, 0x07, 0x06, 0x1A), then read all 16 -> each rsp_rdata matches.
- SPI_MASTER_STATS_EN, CLK_DIV=1 -> 3 writes + 2 reads give wr_count=3, rd_count=2; spi_clk period = 2 clk.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI register-RAM master and slave:
// command codes, field widths, packet lengths and the master FSM state type.
package spi_ram_pkg;

  localparam int ADDR_W      = 4;
  localparam int DATA_W      = 8;
  localparam int CMD_W       = 4;
  localparam int WR_BITS     = 16;
  localparam int RD_CMD_BITS = 8;
  localparam int BIT_CNT_W   = 5;

  localparam logic [CMD_W-1:0] CMD_WR = 4'h1;
  localparam logic [CMD_W-1:0] CMD_RD = 4'h2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } state_t;

  // Builds the on-wire packet; bit 0 is transmitted first. Reads only use
  // the low RD_CMD_BITS, the zero upper byte keeps mosi low afterwards.
  function automatic logic [WR_BITS-1:0] pack_req(
    input logic              write,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    if (write) return {data, addr, CMD_WR};
    else       return {{DATA_W{1'b0}}, addr, CMD_RD};
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator. Counts enabled clk cycles and pulses tick on
// the last cycle of a period of 'limit' cycles, then restarts from zero.
module spi_clk_div #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  assign tick = en && (count == (limit - CNT_W'(1)));

  // Period counter: wraps on tick so every phase starts counting from zero.
  // NOTE: registers are written only with <= so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_ram_master.sv
// SPI mode-0 master producing LSB-first packets for the SPI register RAM.
// Optional build macro SPI_MASTER_STATS_EN adds wr_count/rd_count outputs.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int CS_GAP     = 3,
  parameter int DUMMY_BITS = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              spi_clk,
  output logic              spi_cs,
  output logic              spi_mosi,
  input  logic              spi_miso
`ifdef SPI_MASTER_STATS_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
`endif
);

  localparam int GAP_CYC       = CS_GAP * 2 * CLK_DIV;
  localparam int CNT_W         = $clog2(CLK_DIV * 2 * CS_GAP + 1);
  localparam int RD_DATA_FIRST = RD_CMD_BITS + DUMMY_BITS;
  localparam int RD_DATA_LAST  = RD_DATA_FIRST + DATA_W - 1;
  localparam int WR_LAST       = WR_BITS - 1;

  state_t                 state;
  logic [WR_BITS-1:0]     shift_reg;
  logic [DATA_W-1:0]      rx_shift;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [BIT_CNT_W-1:0]   last_bit;
  logic                   is_write;

  logic [WR_BITS-1:0]     req_packet;
  logic [CNT_W-1:0]       div_limit;
  logic [CNT_W-1:0]       div_count;
  logic                   div_tick;
  logic                   in_window;

  assign req_packet = pack_req(req_write, req_addr, req_wdata);
  assign div_limit  = (state == GAP) ? CNT_W'(GAP_CYC) : CNT_W'(CLK_DIV);
  assign in_window  = !is_write
                   && (bit_cnt >= BIT_CNT_W'(RD_DATA_FIRST))
                   && (bit_cnt <= BIT_CNT_W'(RD_DATA_LAST));

  spi_clk_div #(
    .CNT_W (CNT_W)
  ) u_clk_div (
    .clk   (clk),
    .reset (reset),
    .en    (state != IDLE),
    .clr   (state == IDLE),
    .limit (div_limit),
    .count (div_count),
    .tick  (div_tick)
  );

  // Transaction FSM with registered SPI pins and handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      spi_clk   <= 1'b0;
      spi_cs    <= 1'b1;
      spi_mosi  <= 1'b0;
      shift_reg <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      last_bit  <= '0;
      is_write  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            shift_reg <= req_packet;
            is_write  <= req_write;
            last_bit  <= req_write ? BIT_CNT_W'(WR_LAST) : BIT_CNT_W'(RD_DATA_LAST);
            bit_cnt   <= '0;
            spi_mosi  <= req_packet[0];
            spi_cs    <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (div_tick) begin
            spi_clk <= 1'b1;
            state   <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          // First cycle of the high phase: miso was settled at the last fall.
          if (div_count == '0 && in_window) begin
            rx_shift <= {spi_miso, rx_shift[DATA_W-1:1]};
          end
          if (div_tick) begin
            spi_clk   <= 1'b0;
            shift_reg <= shift_reg >> 1;
            spi_mosi  <= shift_reg[1];
            state     <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (div_tick) begin
            if (bit_cnt == last_bit) begin
              state <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              spi_clk <= 1'b1;
              state   <= SHIFT_HI;
            end
          end
        end
        HOLD: begin
          if (div_tick) begin
            spi_cs   <= 1'b1;
            spi_mosi <= 1'b0;
            state    <= GAP;
            if (!is_write) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= rx_shift;
            end
          end
        end
        GAP: begin
          if (div_tick) begin
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_MASTER_STATS_EN
  // Per-type completion counters, bumped as each transaction enters GAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else if (state == HOLD && div_tick) begin
      if (is_write) wr_count <= wr_count + 16'd1;
      else          rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule
